// File: rtl/regfile_scan_display_pkg.sv
// Shared constants and FSM state type for the register-file scan/display block.
package regfile_scan_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SHOW = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_scan_display_if.sv
// Read-bus and display-pin bundle between the register file, the scanner and the board.
interface regfile_scan_display_if;
  import regfile_scan_display_pkg::*;

  logic                  scan_en;
  logic [3:0]            rd_data;
  logic [IDX_W-1:0]      rd_add;
  logic                  rd_en;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_done;

  // master = the scanner; slave = register file plus board side
  modport master (
    input  scan_en, rd_data,
    output rd_add, rd_en, seg, an, frame_done
  );

  modport slave (
    output scan_en, rd_data,
    input  rd_add, rd_en, seg, an, frame_done
  );

endinterface

// File: rtl/regfile_scan_display_hex_to_seg7.sv
// Nibble to active-low seven-segment pattern, bit order {a,b,c,d,e,f,g}.
module hex_to_seg7 (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/regfile_scan_display.sv
// Walks register-file addresses 0..3, latches each nibble into a shadow copy and
// drives a multiplexed 4-digit active-low seven-segment display from the shadows.
module regfile_scan_display
  import regfile_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   ck,
  input  logic                   rst_n,
  regfile_scan_display_if.master bus
);

  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            shadow_q [NUM_DIGITS];

  logic                  rd_en_q, rd_en_d;
  logic [IDX_W-1:0]      rd_add_q, rd_add_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            nibble_sel;
  logic [6:0]            seg_dec;

  // The first SHOW cycle must already display the nibble being captured, so the
  // decoder looks at the live bus while in REQ and at the shadow copy otherwise.
  assign nibble_sel = (state_q == REQ) ? bus.rd_data : shadow_q[idx_q];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble_sel),
    .seg_o    (seg_dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!bus.scan_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          cnt_d   = '0;
          idx_d   = '0;
        end
        REQ: begin
          state_d = SHOW;
          cnt_d   = CNT_W'(1);
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = REQ;
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from next-state so every pin comes straight from a flop.
  always_comb begin
    rd_en_d      = (state_d == REQ);
    rd_add_d     = idx_d;
    an_d         = AN_OFF;
    seg_d        = SEG_BLANK;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      an_d[idx_d]  = 1'b0;
      seg_d        = seg_dec;
      frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_add_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rd_en_q      <= rd_en_d;
      rd_add_q     <= rd_add_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The bus is only trusted during REQ; elsewhere it may float.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= 4'h0;
      end
    end else if (state_q == REQ) begin
      shadow_q[idx_q] <= bus.rd_data;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_add     = rd_add_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_regfile_scan_display.sv
// Bench: register file with tristate read bus plus the scanner, checked each cycle
// against a slot/position model of the display timeline.
module tb_regfile_scan_display;
  import regfile_scan_display_pkg::*;

  localparam int DIV = 4;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic ck = 1'b0;
  logic rst_n;
  always #5 ck = ~ck;

  regfile_scan_display_if bus ();

  regfile_scan_display #(.REFRESH_DIV(DIV)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: synchronous write port, combinational tristate read
  logic       we;
  logic [1:0] wa;
  logic [3:0] wd;
  logic [3:0] regs [4];

  always @(posedge ck) begin
    if (we) regs[wa] <= wd;
  end

  assign bus.rd_data = bus.rd_en ? regs[bus.rd_add] : 4'bzzzz;

  int         n_checks;
  int         n_fail;
  int         scan_t;      // cycles since scanning (re)started, -1 when idle/reset
  int         cur_pos;
  int         cur_digit;
  logic [3:0] cap [4];     // value each digit captured at its latest read

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic       exp_en;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    exp_en  = 1'b0;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_fd  = 1'b0;
    if (scan_t < 0) begin
      cur_pos   = -1;
      cur_digit = -1;
    end else begin
      cur_pos   = scan_t % DIV;
      cur_digit = (scan_t / DIV) % 4;
      if (cur_pos == 0) begin
        cap[cur_digit] = regs[cur_digit];
        exp_en = 1'b1;
      end else begin
        exp_an[cur_digit] = 1'b0;
        exp_seg = HEX[cap[cur_digit]];
        exp_fd  = (cur_pos == DIV - 1) && (cur_digit == 3);
      end
    end
    chk("rd_en", {7'd0, bus.rd_en}, {7'd0, exp_en});
    if (exp_en)
      chk("rd_add", {6'd0, bus.rd_add}, 8'(cur_digit));
    if (scan_t < 0)
      chk("rd_add_idle", {6'd0, bus.rd_add}, 8'd0);
    chk("an", {4'd0, bus.an}, {4'd0, exp_an});
    chk("seg", {1'b0, bus.seg}, {1'b0, exp_seg});
    chk("frame_done", {7'd0, bus.frame_done}, {7'd0, exp_fd});
  endtask

  // Advance the model for the coming clock edge, then check after it.
  task automatic cycle();
    if (!rst_n) begin
      scan_t = -1;
      for (int i = 0; i < 4; i++) cap[i] = 4'h0;
    end else if (bus.scan_en) begin
      scan_t = (scan_t < 0) ? 0 : scan_t + 1;
    end else begin
      scan_t = -1;
    end
    @(negedge ck);
    check_outputs();
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    cycle();
    we = 1'b0;
    $display("write reg%0d <= %h (digit=%0d pos=%0d)", a, d, cur_digit, cur_pos);
  endtask

  task automatic wait_for(input int pos, input int digit);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      cycle();
      if (cur_pos == pos && cur_digit == digit) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $error("FAIL wait_for observed=timeout expected=pos%0d digit%0d", pos, digit);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    scan_t     = -1;
    cur_pos    = -1;
    cur_digit  = -1;
    for (int i = 0; i < 4; i++) begin
      cap[i]  = 4'h0;
      regs[i] = 4'h0;
    end
    we          = 1'b0;
    wa          = 2'd0;
    wd          = 4'h0;
    bus.scan_en = 1'b0;
    rst_n       = 1'b1;

    #1 rst_n = 1'b0;
    #1 check_outputs();
    $display("reset state checked");
    @(negedge ck);
    rst_n = 1'b1;

    // Preload 1,2,3,4 then run two full frames
    wr(2'd0, 4'h1);
    wr(2'd1, 4'h2);
    wr(2'd2, 4'h3);
    wr(2'd3, 4'h4);
    bus.scan_en = 1'b1;
    cycle();
    chk("first_req_add", {6'd0, bus.rd_add}, 8'd0);
    cycle();
    chk("digit0_seg", {1'b0, bus.seg}, {1'b0, HEX[1]});
    repeat (30) cycle();

    // Write reg2 during its own read: old value this frame, new value next frame
    wait_for(0, 2);
    wr(2'd2, 4'hA);
    chk("digit2_old", {1'b0, bus.seg}, {1'b0, HEX[3]});
    wait_for(1, 2);
    chk("digit2_new", {1'b0, bus.seg}, {1'b0, HEX[10]});

    // Drop scan_en mid-SHOW of digit 1, then re-enable
    wait_for(2, 1);
    bus.scan_en = 1'b0;
    cycle();
    repeat (2) cycle();
    bus.scan_en = 1'b1;
    cycle();
    chk("reenable_add", {6'd0, bus.rd_add}, 8'd0);
    $display("scan_en drop/re-enable done");

    // Async reset in the middle of a REQ cycle
    wait_for(0, 3);
    #1 rst_n = 1'b0;
    #1 scan_t = -1;
    check_outputs();
    wr(2'd0, 4'h0);
    wr(2'd1, 4'h0);
    wr(2'd2, 4'h0);
    wr(2'd3, 4'h0);
    rst_n = 1'b1;
    wait_for(1, 0);
    chk("post_reset_zero", {1'b0, bus.seg}, {1'b0, HEX[0]});

    // Sweep every nibble through reg0
    for (int v = 0; v < 16; v++) begin
      wr(2'd0, 4'(v));
      wait_for(1, 0);
      chk("sweep_seg", {1'b0, bus.seg}, {1'b0, HEX[v]});
    end

    // Random writes and scan_en toggling against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        we = 1'b1;
        wa = 2'($urandom_range(0, 3));
        wd = 4'($urandom_range(0, 15));
      end
      if (bus.scan_en && r >= 97) bus.scan_en = 1'b0;
      else if (!bus.scan_en && r >= 60) bus.scan_en = 1'b1;
      cycle();
      we = 1'b0;
    end
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
